// File: rtl/mul_man_pipe.sv
// Three-stage pipelined mantissa multiplier: multiply, normalise, round, with valid/ready and a tag sideband.
// Build option MUL_MAN_RNE_EN selects round-to-nearest-even; without it the legacy truncating behaviour is used.
module mul_man_pipe #(
    parameter int SIZE_MAN = 24,
    parameter int TAG_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZE_MAN-1:0] i_data_a,
    input  logic [SIZE_MAN-1:0] i_data_b,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_MAN-1:0] o_data_mul,
    output logic [1:0]          o_exp_adj,
    output logic                o_inexact,
    output logic                o_zero,
    output logic [TAG_W-1:0]    o_tag
);
    localparam int W = SIZE_MAN;

    logic [3:1]     vld_pipe;
    logic           en;

    logic [W-1:0]   a1, b1;
    logic [TAG_W-1:0] tag1, tag2;
    logic           zero1, zero2;
    logic [2*W-1:0] p2;

    logic           hi, g, r, s;
    logic [W-1:0]   m;
    logic [W-1:0]   res_data;
    logic [1:0]     res_adj;
    logic           res_inex;

    // Global stall: the whole pipe freezes while the output is held.
    assign en      = !o_valid | i_ready;
    assign o_ready = en;
    assign o_valid = vld_pipe[3];

    // Normalise: product lies in [1,4); pick the window under the leading one.
    assign hi = p2[2*W-1];
    assign m  = hi ? p2[2*W-1:W] : p2[2*W-2:W-1];
    assign g  = hi ? p2[W-1]     : p2[W-2];
    assign r  = hi ? p2[W-2]     : p2[W-3];
    assign s  = hi ? |p2[W-3:0]  : |p2[W-4:0];

`ifdef MUL_MAN_RNE_EN
    logic           inc;
    logic [W:0]     m_rnd;

    assign inc      = g & (r | s | m[0]);
    assign m_rnd    = {1'b0, m} + {{W{1'b0}}, inc};
    // Rounding overflow of an all-ones mantissa renormalises to 1.000...
    assign res_data = m_rnd[W] ? {1'b1, {(W-1){1'b0}}} : m_rnd[W-1:0];
    assign res_adj  = {1'b0, hi} + {1'b0, m_rnd[W]};
    assign res_inex = g | r | s;
`else
    assign res_data = m;
    assign res_adj  = {1'b0, hi};
    assign res_inex = g & (r | s);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe   <= '0;
            a1         <= '0;
            b1         <= '0;
            tag1       <= '0;
            zero1      <= 1'b0;
            p2         <= '0;
            tag2       <= '0;
            zero2      <= 1'b0;
            o_data_mul <= '0;
            o_exp_adj  <= '0;
            o_inexact  <= 1'b0;
            o_zero     <= 1'b0;
            o_tag      <= '0;
        end else if (en) begin
            vld_pipe   <= {vld_pipe[2:1], i_valid};
            // S1: operands, tag, zero/denormal detect
            a1         <= i_data_a;
            b1         <= i_data_b;
            tag1       <= i_tag;
            zero1      <= !(i_data_a[W-1] & i_data_b[W-1]);
            // S2: full-width product
            p2         <= {{W{1'b0}}, a1} * {{W{1'b0}}, b1};
            tag2       <= tag1;
            zero2      <= zero1;
            // S3: normalised, rounded result
            o_data_mul <= zero2 ? '0 : res_data;
            o_exp_adj  <= zero2 ? '0 : res_adj;
            o_inexact  <= zero2 ? 1'b0 : res_inex;
            o_zero     <= zero2;
            o_tag      <= tag2;
        end
    end
endmodule

// File: tb/tb_mul_man_pipe.sv
// Bench for mul_man_pipe: arithmetic reference model + scoreboard, directed literal vectors, stall/reset scenarios.
module tb_mul_man_pipe;
    localparam int W     = 24;
    localparam int TAG_W = 4;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [W-1:0]     i_data_a;
    logic [W-1:0]     i_data_b;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [W-1:0]     o_data_mul;
    logic [1:0]       o_exp_adj;
    logic             o_inexact;
    logic             o_zero;
    logic [TAG_W-1:0] o_tag;

    mul_man_pipe #(.SIZE_MAN(W), .TAG_W(TAG_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_tag(i_tag), .o_valid(o_valid),
        .i_ready(i_ready), .o_data_mul(o_data_mul), .o_exp_adj(o_exp_adj),
        .o_inexact(o_inexact), .o_zero(o_zero), .o_tag(o_tag)
    );

    typedef struct packed {
        logic [W-1:0]     data;
        logic [1:0]       adj;
        logic             inexact;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } res_t;

    int   tests = 0;
    int   fails = 0;
    int   delivered = 0;
    res_t q[$];
    logic [TAG_W-1:0] tag_log[$];
    logic stall_prev = 1'b0;
    res_t held;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: real-valued product scaled to a W-bit mantissa, rounding by remainder comparison.
    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic [TAG_W-1:0] t);
        res_t r;
        logic [63:0] p, kept, rem, half;
        int sh;
        r = '0;
        r.tag = t;
        if (!a[W-1] || !b[W-1]) begin
            r.zero = 1'b1;
            return r;
        end
        p    = 64'(a) * 64'(b);
        sh   = (p >= (64'd1 << (2*W-1))) ? W : W-1;
        r.adj = (sh == W) ? 2'd1 : 2'd0;
        kept = p >> sh;
        rem  = p - (kept << sh);
        half = 64'd1 << (sh-1);
`ifdef MUL_MAN_RNE_EN
        if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        r.inexact = (rem != 0);
        if (kept == (64'd1 << W)) begin
            kept  = 64'd1 << (W-1);
            r.adj = r.adj + 2'd1;
        end
`else
        r.inexact = (rem > half);
`endif
        r.data = kept[W-1:0];
        return r;
    endfunction

    // Scoreboard: results are consumed/inputs accepted at the next rising edge.
    always @(negedge i_clk) begin
        res_t e;
        if (!i_rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", o_data_mul, held.data);
                chk("hold_adj", o_exp_adj, held.adj);
                chk("hold_tag", o_tag, held.tag);
            end
            if (o_valid && !i_ready) chk("stall_ready", o_ready, 0);
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", o_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("res_data", o_data_mul, e.data);
                    chk("res_adj", o_exp_adj, e.adj);
                    chk("res_inexact", o_inexact, e.inexact);
                    chk("res_zero", o_zero, e.zero);
                    chk("res_tag", o_tag, e.tag);
                    delivered++;
                    tag_log.push_back(o_tag);
                end
            end
            if (i_valid && o_ready) q.push_back(model(i_data_a, i_data_b, i_tag));
            stall_prev = o_valid && !i_ready;
            held = '{data: o_data_mul, adj: o_exp_adj, inexact: o_inexact, zero: o_zero, tag: o_tag};
        end
    end

    task automatic run_one(string nm, logic [W-1:0] a, logic [W-1:0] b, logic [TAG_W-1:0] t,
                           logic [W-1:0] ed, logic [1:0] ea, logic ei, logic ez);
        int lat;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_data_a = a; i_data_b = b; i_tag = t; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge i_clk);
            if (o_valid) begin
                lat = n;
                break;
            end
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_data"}, o_data_mul, ed);
        chk({nm, "_adj"}, o_exp_adj, ea);
        chk({nm, "_inexact"}, o_inexact, ei);
        chk({nm, "_zero"}, o_zero, ez);
        chk({nm, "_tag"}, o_tag, t);
    endtask

    task automatic drain(string nm);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_ready = 1'b1;
        for (int n = 0; n < 30 && (q.size() != 0 || o_valid); n++) @(negedge i_clk);
        chk({nm, "_drained"}, q.size(), 0);
    endtask

    function automatic logic [W-1:0] rnd_man();
        logic [W-1:0] v;
        v = W'($urandom);
        if ($urandom_range(7) != 0) v[W-1] = 1'b1;
        if ($urandom_range(7) == 0) v = {W{1'b1}} ^ (v & W'(8'hFF));
        return v;
    endfunction

    logic [W-1:0] bp_a[6] = '{24'h800000, 24'hC00000, 24'hFFF800, 24'h000000, 24'hA5A5A5, 24'hFFFFFF};
    logic [W-1:0] bp_b[6] = '{24'h800000, 24'hC00000, 24'h800400, 24'hC00000, 24'h9ABCDE, 24'hFFFFFF};

    initial begin
        logic acc;
        int idx, d0;
        i_valid = 1'b0; i_ready = 1'b1; i_data_a = '0; i_data_b = '0; i_tag = '0;
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data_mul, 0);
        chk("rst_adj", o_exp_adj, 0);
        chk("rst_flags", {o_inexact, o_zero}, 0);
        chk("rst_tag", o_tag, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        run_one("one_x_one", 24'h800000, 24'h800000, 4'h1, 24'h800000, 2'd0, 1'b0, 1'b0);
        run_one("1p5_sq", 24'hC00000, 24'hC00000, 4'h2, 24'h900000, 2'd1, 1'b0, 1'b0);
`ifdef MUL_MAN_RNE_EN
        run_one("tie_even", 24'h800001, 24'hC00000, 4'h3, 24'hC00002, 2'd0, 1'b1, 1'b0);
        run_one("round_carry", 24'hFFF800, 24'h800400, 4'h4, 24'h800000, 2'd1, 1'b1, 1'b0);
`else
        run_one("tie_even", 24'h800001, 24'hC00000, 4'h3, 24'hC00001, 2'd0, 1'b0, 1'b0);
        run_one("round_carry", 24'hFFF800, 24'h800400, 4'h4, 24'hFFFFFF, 2'd0, 1'b1, 1'b0);
`endif
        run_one("zero_op", 24'h000000, 24'hC00000, 4'h5, 24'h000000, 2'd0, 1'b0, 1'b1);
        drain("directed");

        // Back-pressure: six ops, output stalled in cycles 4..7.
        d0 = delivered;
        tag_log.delete();
        idx = 0;
        for (int c = 0; c < 40 && (idx < 6 || c < 8); c++) begin
            @(posedge i_clk); #1;
            i_ready = !(c >= 4 && c <= 7);
            i_valid = (idx < 6);
            if (idx < 6) begin
                i_data_a = bp_a[idx]; i_data_b = bp_b[idx]; i_tag = TAG_W'(idx);
            end
            @(negedge i_clk);
            if (c == 5) chk("bp_stall_ready", o_ready, 0);
            acc = i_valid && o_ready;
            if (acc) idx++;
        end
        drain("backpressure");
        chk("bp_count", delivered - d0, 6);
        chk("bp_log_size", tag_log.size(), 6);
        for (int i = 0; i < 6 && i < tag_log.size(); i++) chk("bp_tag_order", tag_log[i], i);

        // Async reset with three operations in flight.
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_data_a = bp_a[i]; i_data_b = bp_b[i]; i_tag = TAG_W'(i + 8);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("rst_async_valid", o_valid, 0);
        chk("rst_async_data", o_data_mul, 0);
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge i_clk);
            chk("no_stale", o_valid, 0);
        end
        run_one("post_rst", 24'hC00000, 24'hC00000, 4'hA, 24'h900000, 2'd1, 1'b0, 1'b0);
        drain("post_rst");

        // Random traffic with random back-pressure.
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge i_clk); #1;
            if (!i_valid || acc) begin
                i_valid  = ($urandom_range(3) != 0);
                i_data_a = rnd_man();
                i_data_b = rnd_man();
                i_tag    = TAG_W'($urandom);
            end
            i_ready = ($urandom_range(3) != 0);
            @(negedge i_clk);
            acc = i_valid && o_ready;
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mul_man_pipe.md
Name: mul_man_pipe

Overview:
- Parametrised, pipelined successor to the combinational mantissa multiplier in the FPU_MUL path.
- Multiplies two hidden-bit mantissas, normalises the product, and applies rounding.
- Reports the exponent adjustment (0/1/2) the exponent stage must add.
- Three register stages with valid/ready back-pressure; a sideband tag carries the FFT butterfly index through with its data.

Parameters:
- SIZE_MAN, 24, mantissa width including hidden bit; must be >= 4.
- TAG_W, 4, sideband tag width, passed through unchanged.

Ports:
- i_clk  in  1  clock; all registers on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept an input this cycle.
- i_data_a  in  SIZE_MAN  mantissa A (1.f format; MSB is hidden bit).
- i_data_b  in  SIZE_MAN  mantissa B.
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  output result valid.
- i_ready  in  1  downstream accepts result.
- o_data_mul  out  SIZE_MAN  normalised, rounded mantissa (MSB = 1 unless o_zero).
- o_exp_adj  out  2  exponent increment: 0, 1 or 2.
- o_inexact  out  1  any of guard/round/sticky was set.
- o_zero  out  1  either operand had MSB = 0 (zero/denormal); o_data_mul = 0, o_exp_adj = 0.
- o_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: all stage valids = 0; o_valid = 0; o_data_mul, o_exp_adj, o_inexact, o_zero, o_tag = 0. Reset mid-operation discards all in-flight data.
- Pipeline enable: en = !o_valid | i_ready; o_ready = en. When en = 0, all stages hold (global stall, no bubble collapse).
- Transfers: input accepted on i_valid & o_ready; output consumed on o_valid & i_ready.
- Latency: exactly 3 enabled cycles.
- S1: register operands, tag, and zero detect.
- S2: register the full product P of width 2*SIZE_MAN.
- S3: normalise, round, register outputs.
- A stage's valid bit propagates only when en = 1. Data registers may load regardless of valid; outputs are only meaningful while o_valid = 1.
- Normalise (W = SIZE_MAN):
  - If P[2W-1] = 1: m = P[2W-1:W], g = P[W-1], r = P[W-2], s = |P[W-3:0], base adj = 1.
  - Else: m = P[2W-2:W-1], g = P[W-2], r = P[W-3], s = |P[W-4:0], base adj = 0.
- Round (RNE, see optional feature): inc = g & (r | s | m[0]); m' = m + inc, computed W+1 bits wide.
  - If carry out: o_data_mul = 1 followed by W-1 zeros, o_exp_adj = base adj + 1.
  - Otherwise: o_data_mul = m'[W-1:0], o_exp_adj = base adj.
- o_inexact = g | r | s.
- o_zero forces o_data_mul = 0, o_exp_adj = 0, o_inexact = 0.
- Simultaneous accept and output consume in the same cycle is legal and sustains full throughput (one result per cycle).

Optional Feature:
- Macro: MUL_MAN_RNE_EN.
- Defined: round-to-nearest-even as above.
- Undefined: legacy behaviour.
  - No increment; o_data_mul = m truncated; o_exp_adj = base adj.
  - o_inexact carries the legacy rounding request g & (r | s) instead of g | r | s.

Test Plan:
- 1.0 x 1.0, a = b = 0x800000 (SIZE_MAN 24, RNE) -> 3 cycles later o_valid = 1, o_data_mul = 0x800000, o_exp_adj = 0, o_inexact = 0.
- a = b = 0xC00000 (1.5 x 1.5) -> o_data_mul = 0x900000, o_exp_adj = 1, o_inexact = 0.
- a = 0x800001, b = 0xC00000 (tie, g = 1, r = s = 0, lsb = 1):
  - RNE build -> o_data_mul = 0xC00002, o_inexact = 1.
  - Non-RNE build -> o_data_mul = 0xC00001, o_inexact = 0.
- a = 0x000000, b = 0xC00000, tag = 0x5 -> o_zero = 1, o_data_mul = 0, o_exp_adj = 0, o_tag = 0x5.
- Back-pressure: stream 6 operands with tags 0..5 while holding i_ready = 0 for cycles 4..7 -> o_ready = 0 during the stall, o_valid and outputs held stable, all 6 results delivered in tag order, none lost or duplicated.
- Assert i_rst_n = 0 with 3 operations in flight -> o_valid = 0 immediately (asynchronous); after release, no stale result appears and the next input returns after 3 cycles.
